core_ls_lsu: RTL
================

// Module: core_ls_lsu
// PURPOSE
//  Load/store + writeback stage directly downstream of the EX stage: takes one EX result per valid/ready handshake.
//  Non-memory ops pass through to writeback; loads/stores run a req/gnt/rvalid data-bus transaction.
//  Drives the regfile write port and the MEM-stage forwarding signals to ID.
// PARAMETERS
//  XLEN       32  data/address width
//  PC_WIDTH   32  pc width
//  RFIDX_W    5   register index width
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset; one clock; reset is asynchronous and active-high
//  valid_in     in   1        EX result valid
//  ready_in     out  1        stage can accept
//  valid_out    out  1        result held in DONE
//  ready_out    in   1        retire/commit accepts result
//  i_pc         in   PC_WIDTH pc of instruction
//  i_alu_res    in   XLEN     ALU result / effective address
//  i_rs2_dat    in   XLEN     store data
//  i_rd_wen     in   1        instruction writes rd
//  i_rd_idx     in   RFIDX_W  destination index
//  i_is_load    in   1        load op
//  i_is_store   in   1        store op (never both with i_is_load)
//  i_size       in   2        00 byte, 01 half, 10 word
//  i_unsigned   in   1        zero-extend load
//  mem_req      out  1        bus request
//  mem_we       out  1        1 = write
//  mem_addr     out  XLEN     byte address
//  mem_wdata    out  XLEN     lane-replicated store data
//  mem_wstrb    out  4        byte enables
//  mem_gnt      in   1        request accepted this cycle
//  mem_rvalid   in   1        read data valid
//  mem_rdata    in   XLEN     read word
//  o_pc         out  PC_WIDTH pc of held result
//  o_misalign   out  1        held access misaligned
//  wb_en / wb_idx / wb_data  out 1/RFIDX_W/XLEN  regfile write port
//  rd_wen_mem_fwd / rd_idx_mem_fwd / rd_dat_mem_fwd / rd_dat_vld_mem_fwd  out  forwarding to ID
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; holding registers cleared.
//  FSM: IDLE, REQ, RESP, DONE. ready_in = (IDLE) | (DONE & ready_out).
//  Accept (valid_in & ready_in): capture all i_* inputs.
//   non-mem -> DONE next cycle (latency 1), result = i_alu_res.
//   misaligned (half & addr[0]; word & addr[1:0]!=0) -> DONE, o_misalign=1, no bus access.
//   aligned load/store -> REQ.
//  REQ: mem_req=1, addr/we/wdata/wstrb stable until mem_gnt; on gnt: store -> DONE, load -> RESP.
//  RESP: wait mem_rvalid (earliest cycle after gnt); capture extended data -> DONE.
//  DONE: valid_out=1; on ready_out: new accept same cycle if valid_in, else IDLE.
//  Store: wstrb SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; wdata = byte/half replicated across lanes.
//  Load: shift rdata right by a[1:0]*8, then sign/zero-extend per i_size/i_unsigned.
//  wb_en = valid_out & ready_out & rd_wen & !o_misalign & (rd_idx!=0); wb_idx/wb_data from held regs.
//  Forwarding: rd_wen_mem_fwd = (state!=IDLE) & rd_wen; rd_dat_vld_mem_fwd = DONE.
//  mem_gnt/mem_rvalid outside REQ/RESP ignored.
//  Reset mid-transaction: IDLE immediately, mem_req drops, late rvalid ignored.
// TESTING
//  ADD result 0x1234, rd=5, ready_out=1 -> valid_out next cycle; wb_en, wb_idx=5, wb_data=0x1234.
//  LB addr 0x103, rdata 0x80FF_0000, gnt delayed 3 cycles -> mem_req held 4 cycles; wb_data=0xFFFF_FF80.
//  LHU addr 0x102, rdata 0x8001_0000 -> wb_data=0x0000_8001; LW addr 0x102 -> o_misalign=1, no mem_req, wb_en=0.
//  SB addr 0x101, rs2=0xAB -> mem_we=1, wstrb=0010, wdata=0xABAB_ABAB; wb_en=0.
//  Back-to-back ALU ops, ready_out low 2 cycles -> ready_in=0, output held stable, no drops/duplicates.
//  rst asserted in RESP, then stray rvalid -> IDLE, outputs 0, no wb_en.

Source files
------------

// File: rtl/core_ls_lsu.sv
// Load/store + writeback stage: passes ALU results through, runs req/gnt/rvalid
// bus transactions for loads/stores, drives regfile write and MEM forwarding.
module core_ls_lsu #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter int RFIDX_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_in,
   output logic                ready_in,
   output logic                valid_out,
   input  logic                ready_out,
   input  logic [PC_WIDTH-1:0] i_pc,
   input  logic [XLEN-1:0]     i_alu_res,
   input  logic [XLEN-1:0]     i_rs2_dat,
   input  logic                i_rd_wen,
   input  logic [RFIDX_W-1:0]  i_rd_idx,
   input  logic                i_is_load,
   input  logic                i_is_store,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   output logic                mem_req,
   output logic                mem_we,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [3:0]          mem_wstrb,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic [PC_WIDTH-1:0] o_pc,
   output logic                o_misalign,
   output logic                wb_en,
   output logic [RFIDX_W-1:0]  wb_idx,
   output logic [XLEN-1:0]     wb_data,
   output logic                rd_wen_mem_fwd,
   output logic [RFIDX_W-1:0]  rd_idx_mem_fwd,
   output logic [XLEN-1:0]     rd_dat_mem_fwd,
   output logic                rd_dat_vld_mem_fwd
);

   typedef enum logic [1:0] {
      S_IDLE, S_REQ, S_RESP, S_DONE
   } state_e;

   state_e               state_q;
   logic [PC_WIDTH-1:0]  pc_q;
   logic [XLEN-1:0]      addr_q;
   logic [XLEN-1:0]      wdata_q;
   logic [3:0]           wstrb_q;
   logic [XLEN-1:0]      res_q;
   logic                 rd_wen_q;
   logic [RFIDX_W-1:0]   rd_idx_q;
   logic                 store_q;
   logic [1:0]           size_q;
   logic                 uns_q;
   logic                 mis_q;

   logic                 accept;
   logic                 in_mis;
   logic                 in_mem;
   logic [3:0]           in_wstrb;
   logic [XLEN-1:0]      in_wdata;
   logic [XLEN-1:0]      ld_sh;
   logic [XLEN-1:0]      ld_ext;
   logic                 is_req;
   logic                 is_done;

   assign is_req  = (state_q == S_REQ);
   assign is_done = (state_q == S_DONE);

   assign ready_in = (state_q == S_IDLE)
                   | (is_done & ready_out);
   assign accept   = valid_in & ready_in;
   assign in_mem   = i_is_load | i_is_store;

   // Misalignment and store lane steering from the incoming address.
   always_comb begin
      in_mis   = 1'b0;
      in_wstrb = 4'b1111;
      in_wdata = i_rs2_dat;
      unique case (i_size)
         2'b00: begin
            in_wstrb = 4'b0001 << i_alu_res[1:0];
            in_wdata = {4{i_rs2_dat[7:0]}};
         end
         2'b01: begin
            in_mis   = i_alu_res[0];
            in_wstrb = 4'b0011 << i_alu_res[1:0];
            in_wdata = {2{i_rs2_dat[15:0]}};
         end
         default: begin
            in_mis = |i_alu_res[1:0];
         end
      endcase
   end

   always_comb begin
      ld_sh  = mem_rdata >> {addr_q[1:0], 3'b000};
      ld_ext = ld_sh;
      unique case (size_q)
         2'b00: ld_ext = {{(XLEN-8){~uns_q & ld_sh[7]}},
                          ld_sh[7:0]};
         2'b01: ld_ext = {{(XLEN-16){~uns_q & ld_sh[15]}},
                          ld_sh[15:0]};
         default: ld_ext = ld_sh;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         res_q    <= '0;
         rd_wen_q <= 1'b0;
         rd_idx_q <= '0;
         store_q  <= 1'b0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  pc_q     <= i_pc;
                  addr_q   <= i_alu_res;
                  wdata_q  <= in_wdata;
                  wstrb_q  <= i_is_store ? in_wstrb : 4'b0000;
                  res_q    <= i_alu_res;
                  rd_wen_q <= i_rd_wen;
                  rd_idx_q <= i_rd_idx;
                  store_q  <= i_is_store;
                  size_q   <= i_size;
                  uns_q    <= i_unsigned;
                  mis_q    <= in_mem & in_mis;
                  state_q  <= (in_mem & ~in_mis) ? S_REQ : S_DONE;
               end else if (is_done & ready_out) begin
                  state_q <= S_IDLE;
               end
            end
            S_REQ: begin
               if (mem_gnt) begin
                  state_q <= store_q ? S_DONE : S_RESP;
               end
            end
            S_RESP: begin
               if (mem_rvalid) begin
                  res_q   <= ld_ext;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req   = is_req;
   assign mem_we    = is_req & store_q;
   assign mem_addr  = is_req ? addr_q  : '0;
   assign mem_wdata = is_req ? wdata_q : '0;
   assign mem_wstrb = is_req ? wstrb_q : '0;

   assign valid_out  = is_done;
   assign o_pc       = pc_q;
   assign o_misalign = mis_q;

   assign wb_en   = is_done & ready_out & rd_wen_q & ~mis_q
                  & (rd_idx_q != '0);
   assign wb_idx  = rd_idx_q;
   assign wb_data = res_q;

   assign rd_wen_mem_fwd     = (state_q != S_IDLE) & rd_wen_q;
   assign rd_idx_mem_fwd     = rd_idx_q;
   assign rd_dat_mem_fwd     = res_q;
   assign rd_dat_vld_mem_fwd = is_done;

endmodule
